// File: rtl/windowed_regfile.sv
// windowed_regfile
//   Physical register array seen through a WIN_SIZE-register window that
//   starts at frame pointer FP. FP is moved by CALL (push, advance) and RTN
//   (pop) through an internal return stack. The registered window copy is
//   kept coherent with same-cycle writes, including writes that coincide
//   with a frame move. After reset the array is swept to zero while Busy
//   is high. Rejected requests raise a one-cycle Fault with a code.
//
// Ports
//   Clock, Reset           : rising-edge clock, async active-high reset
//   Rd_Addr/Rd_Wen/Rd_Data : write port D (window-relative address)
//   Rs_Addr/Rs_Wen/Rs_Data : write port S (wins over D on same address)
//   Rm_Addr -> Rm_Out      : combinational read of the registered window
//   Call, Call_Shift, Rtn  : frame move requests
//   window_out             : registered window, slice i = Registers[FP+i]
//   FP, Depth              : frame pointer, return-stack occupancy
//   Busy                   : high during the post-reset clearing sweep
//   Fault, Fault_Code      : 1 overflow, 2 underflow, 3 conflict/busy
module windowed_regfile #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGS    = 32,
  parameter int WIN_SIZE    = 8,
  parameter int STACK_DEPTH = 4,
  localparam int AW = $clog2(NUM_REGS),
  localparam int WW = $clog2(WIN_SIZE),
  localparam int SW = WW + 1,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [WW-1:0]                Rd_Addr,
  input  logic                         Rd_Wen,
  input  logic [DATA_W-1:0]            Rd_Data,
  input  logic [WW-1:0]                Rs_Addr,
  input  logic                         Rs_Wen,
  input  logic [DATA_W-1:0]            Rs_Data,
  input  logic [WW-1:0]                Rm_Addr,
  output logic [DATA_W-1:0]            Rm_Out,
  input  logic                         Call,
  input  logic [SW-1:0]                Call_Shift,
  input  logic                         Rtn,
  output logic [WIN_SIZE*DATA_W-1:0]   window_out,
  output logic [AW-1:0]                FP,
  output logic [DW-1:0]                Depth,
  output logic                         Busy,
  output logic                         Fault,
  output logic [1:0]                   Fault_Code
);

  localparam logic [DW-1:0]   DEPTH_MAX = DW'(STACK_DEPTH);
  localparam logic [SW-1:0]   SHIFT_MAX = SW'(WIN_SIZE);
  localparam logic [AW+1:0]   REGS_LIM  = (AW+2)'(NUM_REGS);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              state;
  logic [AW-1:0]       init_idx;
  logic [DATA_W-1:0]   regs     [NUM_REGS];
  logic [DATA_W-1:0]   win      [WIN_SIZE];
  logic [DATA_W-1:0]   win_nxt  [WIN_SIZE];
  logic [AW-1:0]       stack    [STACK_DEPTH];
  logic [AW-1:0]       stack_top;
  logic [AW-1:0]       rd_phys;
  logic [AW-1:0]       rs_phys;
  logic [AW-1:0]       fp_nxt;
  logic [AW+1:0]       call_end;
  logic                run;
  logic                call_ok;
  logic                rtn_ok;
  logic                move;
  logic                any_req;

  assign run      = (state == S_RUN);
  assign any_req  = Rd_Wen | Rs_Wen | Call | Rtn;
  assign rd_phys  = FP + AW'(Rd_Addr);
  assign rs_phys  = FP + AW'(Rs_Addr);
  // Wide sum so the bound check cannot wrap.
  assign call_end = (AW+2)'(FP) + (AW+2)'(Call_Shift) + (AW+2)'(WIN_SIZE);

  assign call_ok = run && Call && !Rtn && (Depth < DEPTH_MAX) &&
                   (Call_Shift != '0) && (Call_Shift <= SHIFT_MAX) &&
                   (call_end <= REGS_LIM);
  assign rtn_ok  = run && Rtn && !Call && (Depth != '0);
  assign move    = call_ok | rtn_ok;

  always_comb begin
    stack_top = '0;
    for (int j = 0; j < STACK_DEPTH; j++)
      if (Depth == DW'(j + 1)) stack_top = stack[j];
  end

  always_comb begin
    fp_nxt = FP;
    if (call_ok)     fp_nxt = FP + AW'(Call_Shift);
    else if (rtn_ok) fp_nxt = stack_top;
  end

  // Each slot of the next window is the array word at fp_nxt+i, overridden
  // by any same-cycle write whose old-FP physical address lands there. This
  // one rule covers plain writes, writes during CALL and writes during RTN.
  always_comb begin
    for (int i = 0; i < WIN_SIZE; i++) begin
      win_nxt[i] = move ? regs[fp_nxt + AW'(i)] : win[i];
      if (run && Rd_Wen && (rd_phys == fp_nxt + AW'(i))) win_nxt[i] = Rd_Data;
      if (run && Rs_Wen && (rs_phys == fp_nxt + AW'(i))) win_nxt[i] = Rs_Data;
    end
  end

  for (genvar g = 0; g < WIN_SIZE; g++) begin : g_win
    assign window_out[g*DATA_W +: DATA_W] = win[g];
  end

  assign Rm_Out = win[Rm_Addr];

  // Array and return stack: data storage, not reset. The sweep clears the
  // array; stack entries are only read below the current Depth.
  always_ff @(posedge Clock) begin
    if (!run) begin
      regs[init_idx] <= '0;
    end else begin
      if (Rd_Wen) regs[rd_phys] <= Rd_Data;
      if (Rs_Wen) regs[rs_phys] <= Rs_Data;
      if (call_ok)
        for (int j = 0; j < STACK_DEPTH; j++)
          if (Depth == DW'(j)) stack[j] <= FP;
    end
  end

  // Control FSM, window register and fault reporting.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_INIT;
      init_idx   <= '0;
      Busy       <= 1'b1;
      FP         <= '0;
      Depth      <= '0;
      Fault      <= 1'b0;
      Fault_Code <= 2'd0;
      for (int i = 0; i < WIN_SIZE; i++) win[i] <= '0;
    end else begin
      Fault      <= 1'b0;
      Fault_Code <= 2'd0;
      case (state)
        S_INIT: begin
          init_idx <= init_idx + AW'(1);
          if (init_idx == AW'(NUM_REGS - 1)) begin
            state <= S_RUN;
            Busy  <= 1'b0;
          end
          if (any_req) begin
            Fault      <= 1'b1;
            Fault_Code <= 2'd3;
          end
        end
        default: begin
          FP <= fp_nxt;
          if (call_ok)     Depth <= Depth + DW'(1);
          else if (rtn_ok) Depth <= Depth - DW'(1);
          for (int i = 0; i < WIN_SIZE; i++) win[i] <= win_nxt[i];
          if (Call && Rtn) begin
            Fault      <= 1'b1;
            Fault_Code <= 2'd3;
          end else if (Call && !call_ok) begin
            Fault      <= 1'b1;
            Fault_Code <= 2'd1;
          end else if (Rtn && !rtn_ok) begin
            Fault      <= 1'b1;
            Fault_Code <= 2'd2;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_windowed_regfile.sv
module tb_windowed_regfile;
  localparam int DATA_W = 16, NUM_REGS = 32, WIN_SIZE = 8, STACK_DEPTH = 4;
  localparam int AW = 5, WW = 3, SW = 4, DW = 3;
  localparam int WINB = WIN_SIZE * DATA_W;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic [WW-1:0]     Rd_Addr, Rs_Addr, Rm_Addr;
  logic              Rd_Wen, Rs_Wen, Call, Rtn;
  logic [DATA_W-1:0] Rd_Data, Rs_Data, Rm_Out;
  logic [SW-1:0]     Call_Shift;
  logic [WINB-1:0]   window_out;
  logic [AW-1:0]     FP;
  logic [DW-1:0]     Depth;
  logic              Busy, Fault;
  logic [1:0]        Fault_Code;

  windowed_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .WIN_SIZE(WIN_SIZE),
                     .STACK_DEPTH(STACK_DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .Rd_Addr(Rd_Addr), .Rd_Wen(Rd_Wen), .Rd_Data(Rd_Data),
    .Rs_Addr(Rs_Addr), .Rs_Wen(Rs_Wen), .Rs_Data(Rs_Data),
    .Rm_Addr(Rm_Addr), .Rm_Out(Rm_Out),
    .Call(Call), .Call_Shift(Call_Shift), .Rtn(Rtn),
    .window_out(window_out), .FP(FP), .Depth(Depth), .Busy(Busy),
    .Fault(Fault), .Fault_Code(Fault_Code));

  always #5 Clock = ~Clock;

  // Reference model: plain array, integer FP, queue as return stack.
  int mem [NUM_REGS];
  int m_fp;
  int m_stack [$];
  bit m_busy;
  int m_k;
  bit m_fault;
  int m_code;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [WINB-1:0] got, input logic [WINB-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WINB-1:0] exp_win();
    logic [WINB-1:0] w;
    w = '0;
    if (!m_busy)
      for (int i = 0; i < WIN_SIZE; i++) w[i*DATA_W +: DATA_W] = DATA_W'(mem[m_fp + i]);
    return w;
  endfunction

  task automatic model_reset();
    m_fp = 0;
    m_stack.delete();
    m_busy = 1'b1;
    m_k = 0;
    m_fault = 1'b0;
    m_code = 0;
  endtask

  task automatic model_step();
    int shift;
    shift = int'(Call_Shift);
    m_fault = 1'b0;
    m_code = 0;
    if (m_busy) begin
      if (Rd_Wen || Rs_Wen || Call || Rtn) begin m_fault = 1'b1; m_code = 3; end
      mem[m_k] = 0;
      m_k++;
      if (m_k == NUM_REGS) m_busy = 1'b0;
    end else begin
      if (Rd_Wen) mem[m_fp + int'(Rd_Addr)] = int'(Rd_Data);
      if (Rs_Wen) mem[m_fp + int'(Rs_Addr)] = int'(Rs_Data);
      if (Call && Rtn) begin
        m_fault = 1'b1; m_code = 3;
      end else if (Call) begin
        if (m_stack.size() < STACK_DEPTH && shift >= 1 && shift <= WIN_SIZE &&
            m_fp + shift + WIN_SIZE <= NUM_REGS) begin
          m_stack.push_back(m_fp);
          m_fp = m_fp + shift;
        end else begin
          m_fault = 1'b1; m_code = 1;
        end
      end else if (Rtn) begin
        if (m_stack.size() > 0) m_fp = m_stack.pop_back();
        else begin m_fault = 1'b1; m_code = 2; end
      end
    end
  endtask

  task automatic check_all();
    logic [WINB-1:0] w;
    w = exp_win();
    chk_eq("fp", FP, m_fp);
    chk_eq("depth", Depth, m_stack.size());
    chk_eq("busy", Busy, m_busy);
    chk_eq("fault", Fault, m_fault);
    if (m_fault) chk_eq("fault_code", Fault_Code, m_code);
    chk_eq("window", window_out, w);
    chk_eq("rm_out", Rm_Out, w[int'(Rm_Addr)*DATA_W +: DATA_W]);
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    Rd_Wen = 0; Rd_Addr = '0; Rd_Data = '0;
    Rs_Wen = 0; Rs_Addr = '0; Rs_Data = '0;
    Call = 0; Call_Shift = '0; Rtn = 0;
  endtask

  // Asserts reset between edges and checks the asynchronous clear at once.
  task automatic do_reset();
    idle_in();
    #3 Reset = 1'b1;
    #1;
    model_reset();
    chk_eq("arst_fp", FP, 0);
    chk_eq("arst_depth", Depth, 0);
    chk_eq("arst_busy", Busy, 1);
    chk_eq("arst_window", window_out, 0);
    chk_eq("arst_fault", Fault, 0);
    chk_eq("arst_code", Fault_Code, 0);
    repeat (2) @(posedge Clock);
    #3 Reset = 1'b0;
  endtask

  // Runs the clearing sweep; optionally issues a Call at edge call_at.
  task automatic init_sweep(input int call_at);
    int n;
    n = 0;
    while (Busy && n < 100) begin
      if (n == call_at) begin Call = 1; Call_Shift = SW'(2); end
      cycle();
      if (n == call_at) begin
        chk_eq("init_call_code", Fault_Code, 3);
        chk_eq("init_call_fp", FP, 0);
        idle_in();
      end
      n++;
    end
    chk_eq("busy_len", n, NUM_REGS);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 0;
    idle_in();
    Rm_Addr = '0;
    do_reset();
    init_sweep(3);

    // Same-address writes from both ports: S wins.
    Rd_Wen = 1; Rd_Addr = 3; Rd_Data = 16'hBEEF;
    Rs_Wen = 1; Rs_Addr = 3; Rs_Data = 16'h1234; Rm_Addr = 3;
    cycle(); idle_in();
    chk_eq("dual_write_rm", Rm_Out, 16'h1234);
    Rd_Wen = 1; Rd_Addr = 5; Rd_Data = 16'hAAAA; Rm_Addr = 5;
    cycle(); idle_in();
    chk_eq("write5_rm", Rm_Out, 16'hAAAA);
    Rd_Wen = 1; Rd_Addr = 6; Rd_Data = 16'h6666;
    cycle(); idle_in();

    // Call with a coincident write, then return.
    Call = 1; Call_Shift = 6; Rd_Wen = 1; Rd_Addr = 7; Rd_Data = 16'h5A5A;
    cycle(); idle_in();
    chk_eq("call6_fp", FP, 6);
    chk_eq("call6_depth", Depth, 1);
    chk_eq("call6_slot1", window_out[1*DATA_W +: DATA_W], 16'h5A5A);
    chk_eq("call6_slot0", window_out[0 +: DATA_W], 16'h6666);
    Rtn = 1;
    cycle(); idle_in();
    chk_eq("rtn_fp", FP, 0);
    chk_eq("rtn_slot7", window_out[7*DATA_W +: DATA_W], 16'h5A5A);

    // Stack overflow.
    repeat (4) begin Call = 1; Call_Shift = 4; cycle(); end
    chk_eq("four_calls_fp", FP, 16);
    chk_eq("four_calls_depth", Depth, 4);
    cycle(); idle_in();
    chk_eq("ovf_fault", Fault, 1);
    chk_eq("ovf_code", Fault_Code, 1);
    chk_eq("ovf_fp", FP, 16);
    repeat (4) begin Rtn = 1; cycle(); end
    idle_in();
    chk_eq("unwound_fp", FP, 0);

    // Underflow and Call+Rtn conflict.
    Rtn = 1; cycle(); idle_in();
    chk_eq("udf_code", Fault_Code, 2);
    Call = 1; Call_Shift = 2; Rtn = 1; cycle(); idle_in();
    chk_eq("both_code", Fault_Code, 3);
    chk_eq("both_fp", FP, 0);

    // Frame would run past the array end.
    Call = 1; Call_Shift = 8; cycle();
    Call_Shift = 8; cycle();
    Call_Shift = 4; cycle();
    chk_eq("fp20", FP, 20);
    Call_Shift = 8; cycle(); idle_in();
    chk_eq("range_code", Fault_Code, 1);
    chk_eq("range_fp", FP, 20);
    repeat (3) begin Rtn = 1; cycle(); end
    idle_in();

    // Reset mid-call, then reset mid-sweep.
    repeat (2) begin Call = 1; Call_Shift = 3; cycle(); end
    idle_in();
    chk_eq("midcall_depth", Depth, 2);
    do_reset();
    repeat (10) cycle();
    do_reset();
    init_sweep(-1);

    // Randomized traffic against the model.
    repeat (600) begin
      int r;
      Rd_Wen = 1'($urandom_range(0, 1));
      Rd_Addr = WW'($urandom);
      Rd_Data = DATA_W'($urandom);
      Rs_Wen = ($urandom_range(0, 3) == 0);
      Rs_Addr = WW'($urandom);
      Rs_Data = DATA_W'($urandom);
      Rm_Addr = WW'($urandom);
      r = int'($urandom_range(0, 15));
      Call = (r < 5);
      Rtn = (r >= 4 && r < 9);
      Call_Shift = SW'($urandom_range(0, 10));
      cycle();
    end
    idle_in();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/windowed_regfile.md
Name: windowed_regfile

Overview:
- Parametrised successor to the 16-register sliding-window file: a physical register array viewed through a WIN_SIZE-register window at frame pointer FP.
- FP is owned internally, with a hardware return stack for CALL/RTN.
- The window shadow copy is kept coherent with writes in the same cycle as a frame move.
- Adds post-reset array clearing, range and stack fault detection, and a busy handshake.
- Sits between decode/execute and the ALU operand muxes.

Parameters:
DATA_W, 16, register width
NUM_REGS, 32, physical registers (power of two, at least 2*WIN_SIZE)
WIN_SIZE, 8, registers visible in window (power of two)
STACK_DEPTH, 4, maximum nested CALLs
(Derived: AW = clog2(NUM_REGS), WW = clog2(WIN_SIZE), SW = WW+1, DW = clog2(STACK_DEPTH+1))

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Rd_Addr  in  WW  window-relative write address, port D
Rd_Wen  in  1  write enable, port D
Rd_Data  in  DATA_W  write data, port D
Rs_Addr  in  WW  window-relative write address, port S
Rs_Wen  in  1  write enable, port S
Rs_Data  in  DATA_W  write data, port S
Rm_Addr  in  WW  window-relative read address
Rm_Out  out  DATA_W  combinational read of window_out[Rm_Addr]
Call  in  1  push FP, then FP <= FP + Call_Shift
Call_Shift  in  SW  frame advance, legal range 1..WIN_SIZE
Rtn  in  1  pop FP
window_out  out  WIN_SIZE*DATA_W  registered window; slice i = Registers[FP+i]
FP  out  AW  current frame pointer
Depth  out  DW  return-stack occupancy
Busy  out  1  high while the clearing sweep runs
Fault  out  1  one-cycle pulse: request rejected
Fault_Code  out  2  valid with Fault: 1 overflow, 2 underflow, 3 conflict/busy

Behaviour:
- Reset (async) clears FP, Depth, window_out, Fault and Fault_Code to 0 and sets Busy=1 with state INIT. The array itself is not reset.
- INIT state:
  - Writes zero to register index k, for k = 0..NUM_REGS-1, one register per cycle.
  - Busy falls in the cycle after k = NUM_REGS-1 is written; state then moves to RUN.
  - INIT lasts exactly NUM_REGS cycles after Reset deasserts.
- Requests during INIT (any Wen, Call, Rtn):
  - Ignored, with Fault=1 and code 3 in the next cycle.
  - Rm_Out still returns window_out, which is 0.
- Writes in RUN:
  - Physical address = FP + addr, modulo NUM_REGS is never needed because a legal FP keeps FP+WIN_SIZE ≤ NUM_REGS.
  - Writes commit on the rising edge.
  - window_out[addr] updates on the same edge, so Rm_Out sees the new value from the next cycle on.
- Rd_Wen and Rs_Wen to the same address: Rs_Data wins in both the array and the window.
- CALL with Rtn low:
  - Accepted if Depth < STACK_DEPTH, Call_Shift is in 1..WIN_SIZE, and FP + Call_Shift + WIN_SIZE ≤ NUM_REGS.
  - On acceptance: push FP, FP <= FP + Call_Shift, Depth++.
  - window_out[i] <= Registers[newFP+i], with a bypass of any same-cycle write.
  - A write uses the old FP. It lands in window slot (addr - Call_Shift) when addr ≥ Call_Shift; otherwise it is outside the new window and is array-only.
  - Any other CALL is rejected: FP unchanged, Fault code 1.
- RTN with Call low:
  - Accepted if Depth > 0: FP <= popped value, Depth--, window reloaded from the array.
  - A same-cycle write, addressed with the old FP, lands in window slot (addr + oldFP - newFP).
  - When Depth = 0: rejected, Fault code 2.
- Call and Rtn asserted together: both ignored, Fault code 3. Writes still commit.
- Fault timing: Fault and Fault_Code are registered and asserted in the cycle after the request; at most one code per cycle.
- No request blocks on another; the block accepts one frame move per cycle back-to-back.

Test Plan:
- Reset, then hold idle:
  - Busy=1 for exactly 32 cycles, then 0.
  - FP=0, Depth=0, all window slices 0.
  - Call during INIT produces Fault code 3 and FP stays 0.
- Write Rd_Addr=3 with 0xBEEF and Rs_Addr=3 with 0x1234 in the same cycle:
  - Next cycle Rm_Addr=3 gives 0x1234.
  - Separately, write Rd_Addr=5 with 0xAAAA: Rm_Out=0xAAAA one cycle later.
- Call_Shift=6 together with a write Rd_Addr=7 = 0x5A5A:
  - FP=6, Depth=1.
  - Window slot 1 = 0x5A5A; slot 0 = the old slot-6 value.
  - Rtn: FP=0, slot 7 = 0x5A5A.
- Four Calls with shift 4 bring FP to 16 and Depth to 4. A fifth Call gives Fault code 1, FP stays 16. Separately, from FP=20, a Call with shift 8 (20+8+8 > 32) gives Fault code 1.
- Rtn with Depth=0 gives Fault code 2. Call and Rtn asserted together give Fault code 3 and FP unchanged.
- Assert Reset mid-sweep and mid-call (Depth=2):
  - Outputs clear immediately, asynchronously.
  - INIT restarts from k=0 and Busy stays high for the full 32 cycles.
